// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Each access runs IDLE -> ISSUE -> ACK; the ACK exit may hand the port straight to the other requester.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_wrdata0,
    input  logic [1:0]  i_size0,
    input  logic        i_we0,
    output logic        o_ack0,
    output logic        o_err0,
    input  logic        i_req1,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wrdata1,
    input  logic [1:0]  i_size1,
    input  logic        i_we1,
    output logic        o_ack1,
    output logic        o_err1,
    output logic [31:0] o_rddata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wrdata,
    output logic [1:0]  o_mem_size,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rddata
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t      state_reg;
    logic        last_grant_reg;
    logic        err_reg;

    logic        grant_valid;
    logic        grant_sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wrdata;
    logic [1:0]  sel_size;
    logic        sel_we;
    logic [2:0]  sel_bytes;
    logic [32:0] sel_last;
    logic        sel_err;

    // In ACK only the requester that was not just served may win, so a
    // single still-asserted request from the acked side waits for IDLE.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = ~last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    grant_valid = 1'b1;
                    grant_sel   = ~last_grant_reg;
                end else if (i_req0) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b0;
                end else if (i_req1) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b1;
                end
            end
            ACK:     grant_valid = last_grant_reg ? i_req0 : i_req1;
            default: grant_valid = 1'b0;
        endcase
    end

    assign sel_addr   = grant_sel ? i_addr1   : i_addr0;
    assign sel_wrdata = grant_sel ? i_wrdata1 : i_wrdata0;
    assign sel_size   = grant_sel ? i_size1   : i_size0;
    assign sel_we     = grant_sel ? i_we1     : i_we0;

    always_comb begin
        case (sel_size)
            2'b10:   sel_bytes = 3'd2;
            2'b11:   sel_bytes = 3'd4;
            default: sel_bytes = 3'd1;
        endcase
    end

    // Last byte touched, kept in 33 bits so addresses near 2^32 cannot wrap into range.
    assign sel_last = {1'b0, sel_addr} + {30'd0, sel_bytes} - 33'd1;
    assign sel_err  = (sel_size == 2'b01) || (sel_last >= 33'(MEM_BYTES));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            err_reg        <= 1'b0;
            o_ack0         <= 1'b0;
            o_ack1         <= 1'b0;
            o_err0         <= 1'b0;
            o_err1         <= 1'b0;
            o_mem_we       <= 1'b1;
            o_mem_addr     <= 32'd0;
            o_mem_wrdata   <= 32'd0;
            o_mem_size     <= 2'b11;
        end else begin
            case (state_reg)
                IDLE, ACK: begin
                    o_ack0 <= 1'b0;
                    o_ack1 <= 1'b0;
                    o_err0 <= 1'b0;
                    o_err1 <= 1'b0;
                    if (grant_valid) begin
                        o_mem_addr     <= sel_addr;
                        o_mem_wrdata   <= sel_wrdata;
                        o_mem_size     <= sel_size;
                        o_mem_we       <= sel_we | sel_err;
                        last_grant_reg <= grant_sel;
                        err_reg        <= sel_err;
                        state_reg      <= ISSUE;
                    end else begin
                        state_reg      <= IDLE;
                    end
                end
                ISSUE: begin
                    o_mem_we  <= 1'b1;
                    o_ack0    <= ~last_grant_reg;
                    o_ack1    <= last_grant_reg;
                    o_err0    <= ~last_grant_reg & err_reg;
                    o_err1    <= last_grant_reg & err_reg;
                    state_reg <= ACK;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Memory data arrives during ACK, so it is steered through combinationally.
    assign o_rddata = ((o_ack0 || o_ack1) && !err_reg) ? i_mem_rddata : 32'd0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 65536, size of the backing memory in bytes.
REQ-002 Port i_clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Port i_reset  in  1  asynchronous, active-high reset.
REQ-004 Port i_reqN  in  1  access request from requester N (N=0,1; N=0 is the CPU).
REQ-005 Port i_addrN  in  32  byte address for requester N.
REQ-006 Port i_wrdataN  in  32  write data for requester N.
REQ-007 Port i_sizeN  in  2  access size for requester N: 00 byte, 10 half, 11 word; 01 invalid.
REQ-008 Port i_weN  in  1  write enable for requester N, active low.
REQ-009 Port o_ackN  out  1  one-cycle completion strobe to requester N.
REQ-010 Port o_errN  out  1  error flag for requester N, valid only while o_ackN=1.
REQ-011 Port o_rddata  out  32  read data, shared by both requesters, valid while either ack is high.
REQ-012 Port o_mem_addr / o_mem_wrdata / o_mem_size / o_mem_we  out  32/32/2/1  memory port; o_mem_we is active low.
REQ-013 Port i_mem_rddata  in  32  memory read data, valid the cycle after the memory samples o_mem_addr.

Function
REQ-014 States: IDLE, ISSUE, ACK.
REQ-015 Requester contract: i_reqN and its address, data, size and write enable are held stable from assertion until the cycle in which o_ackN=1.
REQ-016 IDLE, no request: stay in IDLE.
REQ-017 IDLE, one request: grant that requester.
REQ-018 IDLE, both requesting: grant the requester not recorded in last_grant (round-robin).
REQ-019 On a grant edge: register the winner's addr, wrdata and size onto the o_mem_* outputs; register o_mem_we = winner's i_weN; record the winner in last_grant; go to ISSUE.
REQ-020 ISSUE lasts exactly 1 cycle; o_mem_we is low only during ISSUE, and only for a valid write; next state ACK.
REQ-021 ACK, ack and data: assert o_ackN for the granted requester for exactly 1 cycle; drive o_rddata = i_mem_rddata, or 0 on error; o_mem_we=1.
REQ-022 ACK, next grant: at the ACK-exit edge, the just-acked requester is excluded from arbitration.
REQ-023 ACK exit: if the other requester is requesting, grant it and go directly to ISSUE; otherwise go to IDLE.
REQ-024 Latency and throughput: request seen at edge E gives ack during the cycle after edge E+1; peak throughput is 1 access per 2 cycles when both request.
REQ-025 Error detection at grant: size 01, or addr + bytes(size) - 1 >= MEM_BYTES (computed in 33 bits, no wrap), flags an error access.
REQ-026 Error access: the access still passes through ISSUE and ACK with o_mem_we=1 (no memory write), o_errN=1, and o_rddata=0.
REQ-027 No ack is ever issued to a requester that is not granted, and o_ack0 and o_ack1 are never both high.
REQ-028 A request deasserted before its grant is dropped silently; a deassertion after the grant does not abort the access.

Reset
REQ-029 While i_reset=1, immediately and regardless of state:
- state=IDLE
- o_ack0=o_ack1=0, o_err0=o_err1=0
- o_mem_we=1, o_mem_addr=0, o_mem_wrdata=0, o_mem_size=11
- o_rddata=0
- last_grant=1, so requester 0 wins the first contended arbitration.
REQ-030 Reset asserted during ISSUE aborts the access; no ack is issued after reset releases.

Verification
REQ-031 Single read: req0 with addr 0x100, size 11, i_we0=1; memory holds 0xDEADBEEF -> o_ack0 pulses 2 cycles after grant, o_rddata=0xDEADBEEF, o_err0=0.
REQ-032 Single write: req1 with addr 0x200, wrdata 0x55, size 00, i_we1=0 -> o_mem_we low for exactly 1 cycle with o_mem_addr=0x200 and o_mem_size=00; then o_ack1 pulses.
REQ-033 Contention: both requesters asserted continuously out of reset -> grant order 0,1,0,1; each ack is 1 cycle; no double service of a requester; 4 accesses complete in 8 cycles after the first grant.
REQ-034 Errors: req0 with addr 0xFFFE, size 11 -> o_ack0=1, o_err0=1, o_rddata=0, o_mem_we never low; req0 with size 01 -> same result.
REQ-035 Reset mid-access: i_reset asserted during ISSUE of a write -> all outputs take their reset values within the same cycle; no ack is issued after release; the next req1 is granted normally.
REQ-036 Back-to-back requester 0 alone: two consecutive requests with no requester 1 -> sequence ISSUE, ACK, IDLE, ISSUE, ACK, i.e. 3 cycles from ack to ack.
